// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic unit: operation select and the
// sequential multiplier/divider control states.
package arith_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_div_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-divide step on the {hi, lo} register pair.
module seq_mul_div_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, hi_i};
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        hi_o   = hi_i;
        lo_o   = lo_i;
        if (op == OP_MUL) begin
            // hi is the accumulator upper half, lo the shrinking multiplier
            if (lo_i[0]) begin
                sum = {1'b0, hi_i} + {1'b0, operand};
            end
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
            hi_o = rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// Iterative one-bit-per-clock multiplier/divider with start/busy/done handshake.
// Define SEQ_MUL_DIV_SIGNED_EN to add the is_signed port (two's complement ops).
module seq_mul_div
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
`ifdef SEQ_MUL_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_low,
    output logic [WIDTH-1:0] out_high,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   out_low_q, out_low_d;
    logic [WIDTH-1:0]   out_high_q, out_high_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   hi_step;
    logic [WIDTH-1:0]   lo_step;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               sgn1;
    logic               sgn2;
    logic [PW-1:0]      prod;

    seq_mul_div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .op      (op_q),
        .operand (opnd_q),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .hi_o    (hi_step),
        .lo_o    (lo_step)
    );

    // Operand magnitudes and signs taken at latch time
    always_comb begin
        mag1 = in1;
        mag2 = in2;
        sgn1 = 1'b0;
        sgn2 = 1'b0;
`ifdef SEQ_MUL_DIV_SIGNED_EN
        sgn1 = is_signed & in1[WIDTH-1];
        sgn2 = is_signed & in2[WIDTH-1];
        if (sgn1) mag1 = ~in1 + WIDTH'(1);
        if (sgn2) mag2 = ~in2 + WIDTH'(1);
`endif
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        busy_d     = (state_q == S_RUN);
        done_d     = (state_q == S_DONE);
        out_low_d  = out_low_q;
        out_high_d = out_high_q;
        div_zero_d = div_zero_q;
        prod       = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    op_d     = op;
                    neg_lo_d = sgn1 ^ sgn2;
                    neg_hi_d = sgn1;
                    if ((op == OP_DIV) && (in2 == '0)) begin
                        state_d    = S_DONE;
                        out_low_d  = '1;
                        out_high_d = in1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(WIDTH);
                        hi_d    = '0;
                        opnd_d  = (op == OP_MUL) ? mag1 : mag2;
                        lo_d    = (op == OP_MUL) ? mag2 : mag1;
                    end
                end
            end
            S_RUN: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Final iteration: apply sign fix-up while writing results
                    state_d    = S_DONE;
                    div_zero_d = 1'b0;
                    if (op_q == OP_MUL) begin
                        prod = {hi_step, lo_step};
                        if (neg_lo_q) prod = ~prod + PW'(1);
                        out_high_d = prod[PW-1:WIDTH];
                        out_low_d  = prod[WIDTH-1:0];
                    end else begin
                        out_low_d  = neg_lo_q ? (~lo_step + WIDTH'(1)) : lo_step;
                        out_high_d = neg_hi_q ? (~hi_step + WIDTH'(1)) : hi_step;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_low_q  <= '0;
            out_high_q <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_low_q  <= out_low_d;
            out_high_q <= out_high_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out_low  = out_low_q;
    assign out_high = out_high_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div (WIDTH=4): directed handshake cases,
// exhaustive sweep and random ops against an arithmetic reference model.
module tb_seq_mul_div;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] out_low;
    logic [W-1:0] out_high;
    logic         div_zero;
`ifdef SEQ_MUL_DIV_SIGNED_EN
    logic         is_signed = 1'b0;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    seq_mul_div #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
`ifdef SEQ_MUL_DIV_SIGNED_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .out_low   (out_low),
        .out_high  (out_high),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic mop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz);
        int unsigned p;
        p = 32'(a) * 32'(b);
        if (mop == 1'b0) begin
            lo = W'(p);
            hi = W'(p >> W);
            dz = 1'b0;
        end else if (b == '0) begin
            lo = '1;
            hi = a;
            dz = 1'b1;
        end else begin
            lo = W'(32'(a) / 32'(b));
            hi = W'(32'(a) % 32'(b));
            dz = 1'b0;
        end
    endfunction

    // Wait for done, counting edges after the accepting edge; bounded
    task automatic wait_done(output int k, output int nbusy);
        k     = 0;
        nbusy = 0;
        do begin
            tick;
            k++;
            if (busy) nbusy++;
        end while (!done && k < 20);
    endtask

    task automatic run_op(input string tag, input logic mop, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] elo, ehi;
        logic         edz;
        int           k, nbusy;
        model(mop, a, b, elo, ehi, edz);
        op    = mop;
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(k, nbusy);
        chk({tag, " latency"}, k, edz ? 1 : W + 1);
        chk({tag, " busy"}, nbusy, edz ? 0 : W);
        chk({tag, " low"}, out_low, elo);
        chk({tag, " high"}, out_high, ehi);
        chk({tag, " dz"}, div_zero, edz);
    endtask

    initial begin
        int k, nbusy;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        in1   = '0;
        in2   = '0;
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst low", out_low, 0);
        chk("rst high", out_high, 0);
        chk("rst dz", div_zero, 0);
        reset = 1'b0;
        tick;

        run_op("mul13x11", 1'b0, 4'd13, 4'd11);
        chk("mul13x11 hi const", out_high, 4'h8);
        chk("mul13x11 lo const", out_low, 4'hF);
        run_op("div13/4", 1'b1, 4'd13, 4'd4);
        run_op("div9/0", 1'b1, 4'd9, 4'd0);
        chk("div9/0 lo const", out_low, 4'hF);
        chk("div9/0 hi const", out_high, 4'd9);
        run_op("mul15x15", 1'b0, 4'd15, 4'd15);
        chk("mul15x15 hi const", out_high, 4'hE);
        chk("mul15x15 lo const", out_low, 4'h1);
        run_op("div15/1", 1'b1, 4'd15, 4'd1);
        run_op("mul_after_dz", 1'b0, 4'd2, 4'd3);

        // start pulsed mid-RUN with other operands is ignored
        op = 1'b0; in1 = 4'd7; in2 = 4'd3; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        op = 1'b1; in1 = 4'd15; in2 = 4'd2; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(k, nbusy);
        chk("ignore latency", k + 2, W + 1);
        chk("ignore low", out_low, 4'h5);
        chk("ignore high", out_high, 4'h1);
        tick;
        tick;
        chk("ignore no extra op", busy, 0);

        // start held through DONE: back-to-back ops
        op = 1'b0; in1 = 4'd5; in2 = 4'd6; start = 1'b1;
        tick;
        op = 1'b1; in1 = 4'd14; in2 = 4'd3;
        wait_done(k, nbusy);
        start = 1'b0;
        chk("b2b first latency", k, W + 1);
        chk("b2b first low", out_low, 4'hE);
        chk("b2b first high", out_high, 4'h1);
        wait_done(k, nbusy);
        chk("b2b second latency", k, W + 1);
        chk("b2b second low", out_low, 4'd4);
        chk("b2b second high", out_high, 4'd2);
        chk("b2b second dz", div_zero, 0);

        // asynchronous reset between edges while running
        op = 1'b0; in1 = 4'd9; in2 = 4'd9; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst low", out_low, 0);
        chk("arst high", out_high, 0);
        chk("arst dz", div_zero, 0);
        #1 reset = 1'b0;
        tick;
        chk("arst no done", done, 0);
        run_op("after_rst", 1'b0, 4'd9, 4'd9);

        // exhaustive sweep, both operations
        for (int o = 0; o < 2; o++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(o == 0 ? "sweep mul" : "sweep div", 1'(o), W'(a), W'(b));
                end
            end
        end

        for (int i = 0; i < 40; i++) begin
            run_op("random", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

`ifdef SEQ_MUL_DIV_SIGNED_EN
        is_signed = 1'b1;
        op = 1'b0; in1 = 4'hD; in2 = 4'd5; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(k, nbusy);
        chk("s mul latency", k, W + 1);
        chk("s mul high", out_high, 4'hF);
        chk("s mul low", out_low, 4'h1);
        op = 1'b1; in1 = 4'h9; in2 = 4'd2; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(k, nbusy);
        chk("s div low", out_low, 4'hD);
        chk("s div high", out_high, 4'hF);
        op = 1'b1; in1 = 4'h8; in2 = 4'hF; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(k, nbusy);
        chk("s minneg low", out_low, 4'h8);
        chk("s minneg high", out_high, 4'h0);
        chk("s minneg dz", div_zero, 0);
        is_signed = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/seq_mul_div.md
Name: seq_mul_div

Overview:
- Iterative multi-cycle multiplier/divider. It is the clocked, parametrised successor to the combinational Multiplier/Divider blocks.
- Uses one shared shift/add-subtract datapath, running one bit per clock, with a start/busy/done handshake.
- Sits beside the combinational arithmetic blocks in the arithmetic unit. It is used where WIDTH is too large for a single-cycle array.

Parameters:
- WIDTH, 4: operand width in bits; any value >= 2.
- CNT_W, $clog2(WIDTH+1): iteration-counter width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  1  0 = multiply, 1 = divide; latched with start.
- in1  input  WIDTH  multiplicand or dividend; latched with start.
- in2  input  WIDTH  multiplier or divisor; latched with start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse when results become valid.
- out_low  output  WIDTH  product low half, or quotient.
- out_high  output  WIDTH  product high half, or remainder.
- div_zero  output  1  last divide had in2 == 0; valid with done.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - busy, done and div_zero = 0.
  - out_low and out_high = 0.
  - Counter and internal registers are cleared.
  - Reset mid-RUN aborts the operation. No done is produced.
- States are IDLE, RUN and DONE.
  - IDLE: start=1 latches op, in1 and in2, loads counter = WIDTH and moves to RUN.
    - Exception: op=1 with in2=0 goes straight to DONE.
  - RUN: one iteration per clock; counter decrements. When counter reaches 1, the next edge goes to DONE.
  - DONE: done=1 for exactly one cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back ops).
    - Otherwise the next state is IDLE.
- Latency and handshake:
  - Start accepted at edge N: done is high in the cycle after edge N+WIDTH+1 (WIDTH RUN cycles, then DONE).
  - Divide by zero: done is high after edge N+1.
  - busy = (state == RUN).
  - start while busy is ignored; operands are not re-latched.
- Outputs:
  - out_low, out_high and div_zero update only on the edge entering DONE.
  - They hold their values until the next entry to DONE or reset; they do not clear on a new start.
- Multiply (unsigned shift-add):
  - 2*WIDTH-bit accumulator.
  - Each iteration: if the multiplier LSB = 1, add the multiplicand into the upper half; then shift right by 1, keeping the carry.
  - Result {out_high, out_low} = in1*in2, exact, no overflow.
- Divide (unsigned restoring):
  - Each iteration: shift {rem, quo} left by 1, then trial-subtract in2 from rem.
  - If no borrow, commit the subtraction and set quo LSB = 1.
  - Result: out_low = floor(in1/in2), out_high = in1 mod in2.
- Divide by zero: out_low = all ones, out_high = in1, div_zero = 1.
- div_zero = 0 after any multiply or any non-zero divide.
- Operand extremes (all-ones × all-ones, all-ones / 1) need no special case and must produce exact results.

Optional Feature:
- Macro: SEQ_MUL_DIV_SIGNED_EN.
- When defined:
  - Adds input port is_signed (1 bit), latched with start.
  - With is_signed=1, operands are two's complement. Magnitudes are taken at latch time, the unsigned core runs, and signs are fixed in DONE.
  - Product sign = sign(in1) XOR sign(in2).
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Most-negative / -1: out_low = most-negative, out_high = 0, no flag.
  - Divide by zero: same outputs as unsigned.
  - Latency is unchanged.
- When undefined: there is no is_signed port and all operations are unsigned.

Decomposition:
- Package arith_pkg holds:
  - op encodings OP_MUL = 1'b0 and OP_DIV = 1'b1;
  - state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module seq_mul_div_step: purely combinational single-iteration slice. Inputs are acc/rem/quo, operand and op; outputs are the next acc/rem/quo.
- The parent holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- WIDTH=4, op=0, in1=13, in2=11 -> done after 5 clocks (edge N+5); out_high=4'h8, out_low=4'hF (143); busy high 4 cycles.
- op=1, in1=13, in2=4 -> out_low=3, out_high=1, div_zero=0; then op=1, in1=9, in2=0 -> done 2 edges after start, out_low=4'hF, out_high=9, div_zero=1.
- start pulsed during RUN with different operands -> ignored; original result delivered. start held high through DONE -> second op accepted, second done exactly WIDTH+1 edges later.
- reset asserted mid-RUN, asynchronously between edges -> busy, done and outputs go to 0 immediately; the next start gives a correct result.
- Exhaustive sweep of all 256 in1/in2 pairs for both ops -> results match the combinational Multiplier/Divider reference model; 15×15 = 225 (high=4'hE, low=4'h1).
- With SEQ_MUL_DIV_SIGNED_EN and is_signed=1:
  - -3×5 -> high=4'hF, low=4'h1 (-15);
  - -7/2 -> out_low=4'hD (-3), out_high=4'hF (-1);
  - -8/-1 -> out_low=4'h8, out_high=0.
